fragment_writer: RTL and testbench
==================================

# fragment_writer

Downstream consumer of the triangle rasterizer's fragment stream. Accepts one fragment per cycle (`{y,x}` point, 1/z value, colour) into a small FIFO and commits each fragment to the framebuffer and zbuffer through a shared memory port arbitrated against the display scan-out. The block also performs a full-frame clear that fills the framebuffer with a colour and the zbuffer with the far-plane value.

## Interface
Parameters:
- SCREEN_WIDTH, 320, pixels per line
- SCREEN_HEIGHT, 240, lines per frame
- FIFO_DEPTH, 8, fragment FIFO entries (power of two, ≥2)
- COLOR_W, 16, framebuffer pixel width (RGB565)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset: asynchronous, active-high
- i_write  in  1  fragment valid (single-cycle strobe per fragment, no backpressure)
- i_point  in  32  {y[15:0], x[15:0]} unsigned pixel coordinates
- i_zdata  in  32  1/z, 16.16 fixed point
- i_color  in  COLOR_W  fragment colour
- i_clear  in  1  clear-request pulse
- i_clear_color  in  COLOR_W  clear colour, sampled when the clear starts
- o_req  out  1  memory port request
- i_gnt  in  1  memory port grant from the arbiter
- o_we  out  1  write strobe, common to the framebuffer and zbuffer
- o_addr  out  17  pixel address, y*SCREEN_WIDTH+x
- o_fb_data  out  COLOR_W  framebuffer write data
- o_zb_data  out  32  zbuffer write data
- o_busy  out  1  FIFO non-empty, or state ≠ S_IDLE, or clear pending
- o_clear_done  out  1  one-cycle pulse at the end of a clear
- o_overflow  out  1  sticky: a fragment was dropped because the FIFO was full

## Operation
- **Push.** On a cycle with i_write=1:
  - If x<SCREEN_WIDTH and y<SCREEN_HEIGHT, write the entry {color, zdata, addr} into the FIFO. addr = y*SCREEN_WIDTH+x, computed at push, truncated to 17 bits.
  - Out-of-screen fragments are discarded silently and never set o_overflow.
- **Full FIFO.** A push while the FIFO is full and no pop happens in the same cycle is dropped, and o_overflow is set. A push and a pop in the same cycle while full both succeed.
- **Clearing o_overflow.** Only reset or the start of a clear clears it.
- **FSM states:** S_IDLE, S_DRAIN, S_CLEAR.
  - S_IDLE → S_CLEAR when clear is pending and the FIFO is empty. A pending clear has priority over fragments that arrive later.
  - S_IDLE → S_DRAIN when the FIFO is non-empty and no clear is pending, or when a clear is pending but the FIFO is not yet empty.
  - S_DRAIN: o_req=1. In each cycle with i_gnt=1 and the FIFO non-empty, pop one entry; the next cycle has o_we=1 with that entry's addr, color and z. When the FIFO empties, return to S_IDLE and drop o_req.
  - S_CLEAR: o_req=1. A 17-bit counter runs from 0 to SCREEN_WIDTH*SCREEN_HEIGHT−1. Each granted cycle writes the counter value as the address, the latched clear colour as framebuffer data, and the far-plane value 32'sd4096 as zbuffer data. After the last address: pulse o_clear_done, go to S_IDLE.
- **Clear pending.** i_clear sets the pending flag in any state. The flag is cleared on entry to S_CLEAR. An i_clear while in S_CLEAR is ignored.
- **During a clear.** Fragments that arrive during a clear are queued and may overflow; they are written after the clear completes.
- **Losing the grant.** When i_gnt drops, writing pauses. Progress and FIFO contents hold, and o_req stays asserted.

## Timing
- All outputs are registered.
- Reset values: o_req=0, o_we=0, o_addr=0, o_fb_data=0, o_zb_data=0, o_busy=0, o_clear_done=0, o_overflow=0. FIFO is emptied, state is S_IDLE, clear is not pending.
- Fragment latency, with i_write at cycle N, starting from S_IDLE with i_gnt held high:
  - FIFO non-empty at N+1
  - S_DRAIN and o_req at N+2
  - o_we at N+3
- Sustained rate: one write per cycle while granted.
- An asserted reset mid-write drops o_we and o_req immediately (asynchronous). Pending fragments and any partial clear are discarded.

## Configuration
- FRAGMENT_WRITER_STATS_EN defined: adds outputs o_frag_count [31:0] and o_drop_count [31:0].
  - o_frag_count counts fragments written.
  - o_drop_count counts FIFO-full drops plus out-of-screen discards.
  - Both are cleared by reset only and saturate at 2^32−1.
- Not defined: these ports and counters do not exist.

## Structure
- Package gpu_pkg holds:
  - SCREEN_WIDTH/SCREEN_HEIGHT defaults
  - INV_FAR_PLANE (32'sd4096) and INV_NEAR_PLANE (32'sd327680)
  - the fragment entry struct {color, z, addr}
  - the writer state enum
- Sub-module frag_fifo: a synchronous FIFO with async reset, push/pop/full/empty, and registered read data available in the pop cycle. FIFO_DEPTH and entry width are parameters.

## Test plan
- Single fragment: point {y=2, x=5}, z=0x00010000, color=0xF800, i_gnt tied 1 → o_we exactly 3 cycles later with o_addr=645, o_zb_data=0x00010000, o_fb_data=0xF800.
- Burst with grant withheld: 9 consecutive fragments, FIFO_DEPTH=8, i_gnt=0 → 8 queued and o_overflow=1. After i_gnt=1: exactly 8 writes in order, then o_busy=0.
- Out-of-screen: x=320, y=0 → no write, o_overflow stays 0, drop count +1 when stats are enabled.
- Clear: i_clear with clear colour 0x001F, i_gnt=1 → 76800 consecutive writes, addresses 0..76799, zb data 4096, then a one-cycle o_clear_done.
- Clear while draining: 4 fragments queued, then i_clear → all 4 fragments are written before the first clear write.
- Mid-clear reset: assert i_rst at clear address 1000 → o_we=0 asynchronously. After release: S_IDLE, o_busy=0, no further writes.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared rasterizer-backend definitions: screen geometry defaults, depth-plane
// constants, the fragment entry layout and the writer state encoding.
package gpu_pkg;

  localparam int DEF_SCREEN_WIDTH  = 320;
  localparam int DEF_SCREEN_HEIGHT = 240;
  localparam int PIX_ADDR_W        = 17;
  localparam int DEF_COLOR_W       = 16;

  // 1/z in 16.16: the far plane sits at z=16, the near plane at z=0.2.
  localparam logic signed [31:0] INV_FAR_PLANE  = 32'sd4096;
  localparam logic signed [31:0] INV_NEAR_PLANE = 32'sd327680;

  typedef struct packed {
    logic [DEF_COLOR_W-1:0] color;
    logic [31:0]            z;
    logic [PIX_ADDR_W-1:0]  addr;
  } frag_entry_t;

  typedef logic [1:0] wr_state_t;

  localparam wr_state_t S_IDLE  = 2'd0;
  localparam wr_state_t S_DRAIN = 2'd1;
  localparam wr_state_t S_CLEAR = 2'd2;

endpackage

// File: rtl/frag_fifo.sv
// Synchronous show-ahead FIFO: the head entry is readable from the storage
// registers during the cycle it is popped. DEPTH must be a power of two.
module frag_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 65
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  // NOTE: every variable gets its default before any branch so no latch is inferred.
  always_comb begin
    do_pop   = i_pop && (count_q != '0);
    do_push  = i_push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  // NOTE: pointers and count carry the reset; the storage array needs none
  // because nothing reads a slot that has not been written since reset.
  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign o_data  = mem_q[rd_ptr_q];
  assign o_full  = (count_q == FULL_CNT);
  assign o_empty = (count_q == '0);
  assign o_count = count_q;

endmodule

// File: rtl/fragment_writer.sv
// Commits rasterizer fragments and full-frame clears to the framebuffer/zbuffer
// port. Optional macro FRAGMENT_WRITER_STATS_EN adds written/dropped counters.
module fragment_writer
  import gpu_pkg::*;
#(
  parameter int SCREEN_WIDTH  = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = DEF_SCREEN_HEIGHT,
  parameter int FIFO_DEPTH    = 8,
  parameter int COLOR_W       = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_write,
  input  logic [31:0]        i_point,
  input  logic [31:0]        i_zdata,
  input  logic [COLOR_W-1:0] i_color,
  input  logic               i_clear,
  input  logic [COLOR_W-1:0] i_clear_color,
  output logic               o_req,
  input  logic               i_gnt,
  output logic               o_we,
  output logic [16:0]        o_addr,
  output logic [COLOR_W-1:0] o_fb_data,
  output logic [31:0]        o_zb_data,
  output logic               o_busy,
  output logic               o_clear_done,
  output logic               o_overflow
`ifdef FRAGMENT_WRITER_STATS_EN
  ,
  output logic [31:0]        o_frag_count,
  output logic [31:0]        o_drop_count
`endif
);

  localparam int ADDR_W = PIX_ADDR_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_WIDTH * SCREEN_HEIGHT - 1);

  typedef struct packed {
    logic [COLOR_W-1:0] color;
    logic [31:0]        z;
    logic [ADDR_W-1:0]  addr;
  } entry_t;

  entry_t           push_entry, head_entry;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count, count_next;
  logic [15:0]      pt_x, pt_y;
  logic             in_screen, push_req, push_ok, pop, drop, oos;

  wr_state_t          state_q, state_d;
  logic [ADDR_W-1:0]  clr_cnt_q, clr_cnt_d;
  logic [COLOR_W-1:0] clr_color_q, clr_color_d;
  logic               clr_pend_q, clr_pend_d;
  logic               last_wr_q, last_wr_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [COLOR_W-1:0] fb_q, fb_d;
  logic [31:0]        zb_q, zb_d;
  logic               busy_q, busy_d;
  logic               clear_done_q, clear_done_d;
  logic               overflow_q, overflow_d;

  assign pt_x      = i_point[15:0];
  assign pt_y      = i_point[31:16];
  assign in_screen = ({1'b0, pt_x} < 17'(SCREEN_WIDTH)) && ({1'b0, pt_y} < 17'(SCREEN_HEIGHT));

  always_comb begin
    push_entry.color = i_color;
    push_entry.z     = i_zdata;
    push_entry.addr  = ADDR_W'(pt_y) * ADDR_W'(SCREEN_WIDTH) + ADDR_W'(pt_x);
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop        = (state_q == S_DRAIN) && i_gnt && !fifo_empty;
  assign push_req   = i_write && in_screen;
  assign push_ok    = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;
  assign oos        = i_write && !in_screen;
  assign count_next = fifo_count + CNT_W'(push_ok) - CNT_W'(pop);

  frag_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push_ok),
    .i_pop   (pop),
    .i_data  (push_entry),
    .o_data  (head_entry),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (fifo_count)
  );

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    clr_pend_d  = clr_pend_q || (i_clear && (state_q != S_CLEAR));
    last_wr_d   = 1'b0;
    req_d       = req_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    fb_d        = fb_q;
    zb_d        = zb_q;
    overflow_d  = overflow_q;

    case (state_q)
      S_IDLE: begin
        if (clr_pend_q && fifo_empty) begin
          state_d     = S_CLEAR;
          clr_pend_d  = 1'b0;
          clr_cnt_d   = '0;
          clr_color_d = i_clear_color;
          overflow_d  = 1'b0;
          req_d       = 1'b1;
        end else if (!fifo_empty) begin
          state_d = S_DRAIN;
          req_d   = 1'b1;
        end
      end
      S_DRAIN: begin
        if (pop) begin
          we_d   = 1'b1;
          addr_d = head_entry.addr;
          fb_d   = head_entry.color;
          zb_d   = head_entry.z;
        end
        if (count_next == '0) begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      end
      S_CLEAR: begin
        if (i_gnt) begin
          we_d   = 1'b1;
          addr_d = clr_cnt_q;
          fb_d   = clr_color_q;
          zb_d   = INV_FAR_PLANE;
          if (clr_cnt_q == LAST_ADDR) begin
            state_d   = S_IDLE;
            req_d     = 1'b0;
            last_wr_d = 1'b1;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase

    if (drop) overflow_d = 1'b1;

    // Busy mirrors the state the registers will hold next cycle.
    busy_d       = (count_next != '0) || (state_d != S_IDLE) || clr_pend_d;
    clear_done_d = last_wr_q;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      clr_cnt_q    <= '0;
      clr_color_q  <= '0;
      clr_pend_q   <= 1'b0;
      last_wr_q    <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      fb_q         <= '0;
      zb_q         <= '0;
      busy_q       <= 1'b0;
      clear_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      clr_color_q  <= clr_color_d;
      clr_pend_q   <= clr_pend_d;
      last_wr_q    <= last_wr_d;
      req_q        <= req_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      fb_q         <= fb_d;
      zb_q         <= zb_d;
      busy_q       <= busy_d;
      clear_done_q <= clear_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign o_req        = req_q;
  assign o_we         = we_q;
  assign o_addr       = addr_q;
  assign o_fb_data    = fb_q;
  assign o_zb_data    = zb_q;
  assign o_busy       = busy_q;
  assign o_clear_done = clear_done_q;
  assign o_overflow   = overflow_q;

`ifdef FRAGMENT_WRITER_STATS_EN
  logic [31:0] frag_count_q, frag_count_d;
  logic [31:0] drop_count_q, drop_count_d;

  // A pop always becomes a write on the next edge, so count it there.
  always_comb begin
    frag_count_d = frag_count_q;
    drop_count_d = drop_count_q;
    if (pop && (frag_count_q != '1))           frag_count_d = frag_count_q + 32'd1;
    if ((drop || oos) && (drop_count_q != '1)) drop_count_d = drop_count_q + 32'd1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frag_count_q <= '0;
      drop_count_q <= '0;
    end else begin
      frag_count_q <= frag_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign o_frag_count = frag_count_q;
  assign o_drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_fragment_writer.sv
// Directed bench for fragment_writer: single-fragment vectors, a withheld-grant
// burst, clear behind queued fragments, and reset in the middle of a clear.
module tb_fragment_writer;

  localparam int NPIX = 320 * 240;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_write;
  logic [31:0] i_point;
  logic [31:0] i_zdata;
  logic [15:0] i_color;
  logic        i_clear;
  logic [15:0] i_clear_color;
  logic        o_req;
  logic        i_gnt;
  logic        o_we;
  logic [16:0] o_addr;
  logic [15:0] o_fb_data;
  logic [31:0] o_zb_data;
  logic        o_busy;
  logic        o_clear_done;
  logic        o_overflow;
`ifdef FRAGMENT_WRITER_STATS_EN
  logic [31:0] o_frag_count;
  logic [31:0] o_drop_count;
`endif

  fragment_writer #(
    .SCREEN_WIDTH  (320),
    .SCREEN_HEIGHT (240),
    .FIFO_DEPTH    (8),
    .COLOR_W       (16)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_write       (i_write),
    .i_point       (i_point),
    .i_zdata       (i_zdata),
    .i_color       (i_color),
    .i_clear       (i_clear),
    .i_clear_color (i_clear_color),
    .o_req         (o_req),
    .i_gnt         (i_gnt),
    .o_we          (o_we),
    .o_addr        (o_addr),
    .o_fb_data     (o_fb_data),
    .o_zb_data     (o_zb_data),
    .o_busy        (o_busy),
    .o_clear_done  (o_clear_done),
    .o_overflow    (o_overflow)
`ifdef FRAGMENT_WRITER_STATS_EN
    ,
    .o_frag_count  (o_frag_count),
    .o_drop_count  (o_drop_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Returns 1 ns after a rising edge: outputs are settled, inputs set now are
  // sampled at the following edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] y;
    logic [15:0] x;
    logic [31:0] z;
    logic [15:0] color;
    logic        exp_valid;
    logic [16:0] exp_addr;
  } vec_t;

  vec_t vecs[8];

  int nw, first_c, last_c, nfrag, nclr, bad, done_cnt, done_ok, last_we_c, found, stray;

  initial begin
    vecs[0] = '{16'd2,      16'd5,      32'h0001_0000, 16'hF800, 1'b1, 17'd645};
    vecs[1] = '{16'd0,      16'd0,      32'h7FFF_FFFF, 16'h07E0, 1'b1, 17'd0};
    vecs[2] = '{16'd239,    16'd319,    32'h0000_1000, 16'hFFFF, 1'b1, 17'd76799};
    vecs[3] = '{16'd0,      16'd320,    32'h0000_0001, 16'h1111, 1'b0, 17'd0};
    vecs[4] = '{16'd240,    16'd0,      32'h0000_0002, 16'h2222, 1'b0, 17'd0};
    vecs[5] = '{16'd1,      16'd0,      32'h0005_0000, 16'h1234, 1'b1, 17'd320};
    vecs[6] = '{16'hFFFF,   16'hFFFF,   32'h0000_0003, 16'h3333, 1'b0, 17'd0};
    vecs[7] = '{16'd0,      16'd319,    32'h8000_0000, 16'hABCD, 1'b1, 17'd319};

    i_rst = 1'b1; i_write = 1'b0; i_point = '0; i_zdata = '0; i_color = '0;
    i_clear = 1'b0; i_clear_color = '0; i_gnt = 1'b1;
    #1;
    check("rst_req", o_req, 0);
    check("rst_we", o_we, 0);
    check("rst_addr", o_addr, 0);
    check("rst_fb", o_fb_data, 0);
    check("rst_zb", o_zb_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_clear_done, 0);
    check("rst_ovf", o_overflow, 0);
    tick(); tick();
    i_rst = 1'b0;
    tick(); tick();
    check("idle_busy", o_busy, 0);
    check("idle_req", o_req, 0);

    // Single fragments with grant held high.
    for (int i = 0; i < 8; i++) begin
      i_write = 1'b1; i_point = {vecs[i].y, vecs[i].x}; i_zdata = vecs[i].z; i_color = vecs[i].color;
      tick();
      i_write = 1'b0;
      check($sformatf("v%0d_busy_n1", i), o_busy, vecs[i].exp_valid);
      tick();
      check($sformatf("v%0d_req_n2", i), o_req, vecs[i].exp_valid);
      check($sformatf("v%0d_we_n2", i), o_we, 0);
      tick();
      check($sformatf("v%0d_we_n3", i), o_we, vecs[i].exp_valid);
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_addr", i), o_addr, vecs[i].exp_addr);
        check($sformatf("v%0d_fb", i), o_fb_data, vecs[i].color);
        check($sformatf("v%0d_zb", i), o_zb_data, vecs[i].z);
      end
      tick();
      check($sformatf("v%0d_we_n4", i), o_we, 0);
      check($sformatf("v%0d_busy_n4", i), o_busy, 0);
      check($sformatf("v%0d_ovf", i), o_overflow, 0);
    end
`ifdef FRAGMENT_WRITER_STATS_EN
    check("stats_frag_a", o_frag_count, 5);
    check("stats_drop_a", o_drop_count, 3);
`endif

    // Burst of 9 with the grant withheld: 8 queue, the 9th is dropped.
    i_gnt = 1'b0;
    for (int i = 0; i < 9; i++) begin
      i_write = 1'b1; i_point = {16'd10, 16'(i)}; i_zdata = 32'h1000 + i; i_color = 16'h0100 + 16'(i);
      tick();
    end
    i_write = 1'b0;
    tick(); tick();
    check("burst_ovf", o_overflow, 1);
    check("burst_req_nogrant", o_req, 1);
    check("burst_we_nogrant", o_we, 0);
    check("burst_busy", o_busy, 1);
    i_gnt = 1'b1;
    nw = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (o_we) begin
        if (nw < 8) begin
          check($sformatf("burst_addr%0d", nw), o_addr, 17'd3200 + 17'(nw));
          check($sformatf("burst_fb%0d", nw), o_fb_data, 16'h0100 + 16'(nw));
          check($sformatf("burst_zb%0d", nw), o_zb_data, 32'h1000 + nw);
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        nw++;
      end
    end
    check("burst_writes", nw, 8);
    check("burst_back_to_back", last_c - first_c, 7);
    check("burst_busy_after", o_busy, 0);
    check("burst_req_after", o_req, 0);
    check("burst_ovf_sticky", o_overflow, 1);
`ifdef FRAGMENT_WRITER_STATS_EN
    check("stats_frag_b", o_frag_count, 13);
    check("stats_drop_b", o_drop_count, 4);
`endif

    // Four fragments queued, then a clear: fragments go first, then the full clear.
    i_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      i_write = 1'b1; i_point = {16'd4, 16'(i)}; i_zdata = 32'hA0 + i; i_color = 16'h0A00 + 16'(i);
      tick();
    end
    i_write = 1'b0;
    tick(); tick(); tick();
    i_clear = 1'b1; i_clear_color = 16'h001F;
    tick();
    i_clear = 1'b0;
    check("cq_busy", o_busy, 1);
    check("cq_we", o_we, 0);
    i_gnt = 1'b1;
    nfrag = 0; nclr = 0; bad = 0; done_cnt = 0; done_ok = 0; last_we_c = -10;
    for (int c = 0; c < 80000 && done_cnt == 0; c++) begin
      tick();
      if (o_clear_done) begin
        done_cnt++;
        done_ok = (last_we_c == c - 1) && (nclr == NPIX);
      end
      if (o_we) begin
        last_we_c = c;
        if (nfrag < 4 && nclr == 0) begin
          check($sformatf("cq_frag_addr%0d", nfrag), o_addr, 17'd1280 + 17'(nfrag));
          check($sformatf("cq_frag_fb%0d", nfrag), o_fb_data, 16'h0A00 + 16'(nfrag));
          nfrag++;
        end else begin
          if (nclr == 0) check("cq_ovf_cleared", o_overflow, 0);
          if (o_addr !== 17'(nclr) || o_fb_data !== 16'h001F || o_zb_data !== 32'd4096) bad++;
          nclr++;
        end
      end
      i_clear = (nclr == 100);
    end
    i_clear = 1'b0;
    check("cq_frags_first", nfrag, 4);
    check("clear_writes", nclr, NPIX);
    check("clear_data_errs", bad, 0);
    check("clear_done_seen", done_cnt, 1);
    check("clear_done_after_last", done_ok, 1);
    tick();
    check("clear_done_one_cycle", o_clear_done, 0);
    check("clear_busy_after", o_busy, 0);
    check("clear_we_after", o_we, 0);

    // Reset in the middle of a clear, with a fragment queued behind it.
    i_clear = 1'b1; i_clear_color = 16'h7777;
    tick();
    i_clear = 1'b0;
    found = 0;
    for (int c = 0; c < 3000 && found == 0; c++) begin
      i_write = (c == 3); i_point = {16'd5, 16'd5}; i_zdata = 32'h55; i_color = 16'h5555;
      tick();
      if (o_we && o_addr == 17'd1000) found = 1;
    end
    i_write = 1'b0;
    check("mid_reach_1000", found, 1);
    #2;
    i_rst = 1'b1;
    #1;
    check("mid_rst_we", o_we, 0);
    check("mid_rst_req", o_req, 0);
    check("mid_rst_busy", o_busy, 0);
    #3;
    i_rst = 1'b0;
    stray = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (o_we || o_req || o_busy) stray++;
    end
    check("post_rst_quiet", stray, 0);
    check("post_rst_done", o_clear_done, 0);
    check("post_rst_ovf", o_overflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
